// File: rtl/jellyvl_timer_pkg.sv
// Shared time-base definitions: default widths, fixed-point step type and
// the slew FSM state encoding. Used by the adjustable timer, the periodic
// trigger and phase-compare blocks.
package jellyvl_timer_pkg;

    localparam int unsigned DEF_TIMER_WIDTH = 64;
    localparam int unsigned DEF_FRAC_WIDTH  = 16;
    localparam int unsigned DEF_STEP_WIDTH  = 32;
    localparam int unsigned DEF_ADJ_WIDTH   = 32;
    localparam int unsigned DEF_SLEW_WIDTH  = 16;

    // Unsigned Q16.16 per-cycle increment at the default widths
    typedef logic [DEF_STEP_WIDTH-1:0] step_t;

    typedef enum logic {
        IDLE = 1'b0,
        SLEW = 1'b1
    } state_t;

endpackage

// File: rtl/jellyvl_slew_clamp.sv
// Per-cycle correction limiter (purely combinational).
//   remaining  : signed outstanding correction, integer units
//   slew_limit : max correction magnitude per cycle (0 behaves as 1)
//   step_int   : integer part of the current step
//   corr       : signed correction to apply this cycle; negative corrections
//                never exceed step_int so time stays monotonic
module jellyvl_slew_clamp #(
    parameter int unsigned ADJ_WIDTH      = 32,
    parameter int unsigned SLEW_WIDTH     = 16,
    parameter int unsigned STEP_INT_WIDTH = 16
) (
    input  logic signed [ADJ_WIDTH:0]      remaining,
    input  logic        [SLEW_WIDTH-1:0]   slew_limit,
    input  logic        [STEP_INT_WIDTH-1:0] step_int,
    output logic signed [ADJ_WIDTH:0]      corr
);

    localparam int unsigned RW = ADJ_WIDTH + 1;
    localparam int unsigned M1 = (RW > SLEW_WIDTH) ? RW : SLEW_WIDTH;
    localparam int unsigned CW = (M1 > STEP_INT_WIDTH) ? M1 : STEP_INT_WIDTH;

    logic [CW-1:0] mag;
    logic [CW-1:0] lim;
    logic [CW-1:0] sint;
    logic [CW-1:0] lim_pos;
    logic [CW-1:0] lim_neg;

    // Magnitude clamp; remaining is never the most negative RW-bit value
    always_comb begin
        mag     = remaining[RW-1] ? CW'(-remaining) : CW'(remaining);
        lim     = (slew_limit == '0) ? CW'(1) : CW'(slew_limit);
        sint    = CW'(step_int);
        lim_pos = (mag < lim) ? mag : lim;
        lim_neg = (lim_pos < sint) ? lim_pos : sint;
        corr    = '0;
        if (remaining[RW-1]) begin
            corr = -$signed(RW'(lim_neg));
        end else if (remaining != '0) begin
            corr = $signed(RW'(lim_pos));
        end
    end

endmodule

// File: rtl/jellyvl_adjustable_timer.sv
// Free-running fixed-point time base with hard load and slew-limited offset
// correction.
//   clk, reset     : clock, synchronous active-high reset
//   enable         : advance time when high
//   step           : per-cycle increment, unsigned fixed point
//   slew_limit     : max integer correction per cycle (0 behaves as 1)
//   set_valid/time : load set_time (highest priority)
//   adj_valid/ready/value : signed correction request handshake
//   adj_busy       : correction currently being slewed
//   current_time   : integer part of the accumulator
module jellyvl_adjustable_timer
    import jellyvl_timer_pkg::*;
#(
    parameter int unsigned TIMER_WIDTH = DEF_TIMER_WIDTH,
    parameter int unsigned FRAC_WIDTH  = DEF_FRAC_WIDTH,
    parameter int unsigned STEP_WIDTH  = DEF_STEP_WIDTH,
    parameter int unsigned ADJ_WIDTH   = DEF_ADJ_WIDTH,
    parameter int unsigned SLEW_WIDTH  = DEF_SLEW_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [STEP_WIDTH-1:0]       step,
    input  logic [SLEW_WIDTH-1:0]       slew_limit,
    input  logic                        set_valid,
    input  logic [TIMER_WIDTH-1:0]      set_time,
    input  logic                        adj_valid,
    output logic                        adj_ready,
    input  logic signed [ADJ_WIDTH-1:0] adj_value,
    output logic                        adj_busy,
    output logic [TIMER_WIDTH-1:0]      current_time
);

    localparam int unsigned AW  = TIMER_WIDTH + FRAC_WIDTH;
    localparam int unsigned RW  = ADJ_WIDTH + 1;
    localparam int unsigned SIW = STEP_WIDTH - FRAC_WIDTH;

    state_t                state;
    state_t                state_next;
    logic [AW-1:0]         acc;
    logic [AW-1:0]         acc_next;
    logic signed [RW-1:0]  remaining;
    logic signed [RW-1:0]  remaining_next;
    logic signed [RW-1:0]  corr;
    logic                  accept;

    jellyvl_slew_clamp #(
        .ADJ_WIDTH      (ADJ_WIDTH),
        .SLEW_WIDTH     (SLEW_WIDTH),
        .STEP_INT_WIDTH (SIW)
    ) u_slew_clamp (
        .remaining  (remaining),
        .slew_limit (slew_limit),
        .step_int   (step[STEP_WIDTH-1:FRAC_WIDTH]),
        .corr       (corr)
    );

    assign adj_ready    = (state == IDLE) && !set_valid;
    assign accept       = adj_valid && adj_ready;
    assign current_time = acc[AW-1:FRAC_WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            adj_busy  <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            remaining <= remaining_next;
            adj_busy  <= (state_next == SLEW);
        end
    end

    // Next-state: load beats everything; an accepted request overwrites the
    // (necessarily zero) idle remaining after this cycle's uncorrected step
    always_comb begin
        state_next     = state;
        acc_next       = acc;
        remaining_next = remaining;
        if (set_valid) begin
            acc_next       = {set_time, FRAC_WIDTH'(0)};
            remaining_next = '0;
            state_next     = IDLE;
        end else begin
            if (enable) begin
                acc_next       = acc + AW'(step) + (AW'(corr) << FRAC_WIDTH);
                remaining_next = remaining - corr;
                if ((state == SLEW) && (remaining_next == '0)) begin
                    state_next = IDLE;
                end
            end
            if (accept) begin
                remaining_next = RW'(adj_value);
                state_next     = (adj_value != '0) ? SLEW : IDLE;
            end
        end
    end

endmodule

// File: tb/tb_jellyvl_adjustable_timer.sv
// Directed bench for jellyvl_adjustable_timer: vector table plus a hand
// sequence for wrap-around and enable hold during slew.
module tb_jellyvl_adjustable_timer;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [31:0]        step;
    logic [15:0]        slew_limit;
    logic               set_valid;
    logic [63:0]        set_time;
    logic               adj_valid;
    logic               adj_ready;
    logic signed [31:0] adj_value;
    logic               adj_busy;
    logic [63:0]        current_time;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jellyvl_adjustable_timer dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .step         (step),
        .slew_limit   (slew_limit),
        .set_valid    (set_valid),
        .set_time     (set_time),
        .adj_valid    (adj_valid),
        .adj_ready    (adj_ready),
        .adj_value    (adj_value),
        .adj_busy     (adj_busy),
        .current_time (current_time)
    );

    // exp_ready is checked before the edge, exp_time/exp_busy after it
    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] stp;
        logic [15:0] slw;
        logic        setv;
        logic [63:0] sett;
        logic        adjv;
        logic [31:0] adjval;
        logic [63:0] exp_time;
        logic        exp_busy;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic en, logic [31:0] stp, logic [15:0] slw,
                                logic setv, logic [63:0] sett, logic adjv, logic [31:0] adjval,
                                logic [63:0] et, logic eb, logic er);
        vec_t v;
        v.rst = rst; v.en = en; v.stp = stp; v.slw = slw;
        v.setv = setv; v.sett = sett; v.adjv = adjv; v.adjval = adjval;
        v.exp_time = et; v.exp_busy = eb; v.exp_ready = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        reset      = v.rst;
        enable     = v.en;
        step       = v.stp;
        slew_limit = v.slw;
        set_valid  = v.setv;
        set_time   = v.sett;
        adj_valid  = v.adjv;
        adj_value  = v.adjval;
        #1;
        check({tag, ".ready"}, 64'(adj_ready), 64'(v.exp_ready));
        @(posedge clk);
        #1;
        check({tag, ".time"}, current_time, v.exp_time);
        check({tag, ".busy"}, 64'(adj_busy), 64'(v.exp_busy));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; step = '0; slew_limit = '0;
        set_valid = 1'b0; set_time = '0; adj_valid = 1'b0; adj_value = '0;
        repeat (2) @(posedge clk);

        // reset and fractional stepping (1.5 per cycle)
        vecs.push_back(mk(1, 0, 32'h0000_0000, 16'd0, 0, 64'd0, 0, 32'd0, 64'd0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h0001_8000, 16'd0, 0, 64'd0, 0, 32'd0, 64'd1, 0, 1));
        vecs.push_back(mk(0, 1, 32'h0001_8000, 16'd0, 0, 64'd0, 0, 32'd0, 64'd3, 0, 1));
        vecs.push_back(mk(0, 1, 32'h0001_8000, 16'd0, 0, 64'd0, 0, 32'd0, 64'd4, 0, 1));
        vecs.push_back(mk(0, 1, 32'h0001_8000, 16'd0, 0, 64'd0, 0, 32'd0, 64'd6, 0, 1));
        // positive slew +10, limit 4
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd4, 1, 64'd100, 0, 32'd0, 64'd100, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd4, 0, 64'd0, 1, 32'd10, 64'd101, 1, 1));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd4, 0, 64'd0, 0, 32'd0, 64'd106, 1, 0));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd4, 0, 64'd0, 0, 32'd0, 64'd111, 1, 0));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd4, 0, 64'd0, 0, 32'd0, 64'd114, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd4, 0, 64'd0, 0, 32'd0, 64'd115, 0, 1));
        // negative slew -10, clamped to step_int=2 so time holds
        vecs.push_back(mk(0, 1, 32'h0002_0000, 16'd4, 1, 64'd200, 0, 32'd0, 64'd200, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0002_0000, 16'd4, 0, 64'd0, 1, -32'sd10, 64'd202, 1, 1));
        vecs.push_back(mk(0, 1, 32'h0002_0000, 16'd4, 0, 64'd0, 0, 32'd0, 64'd202, 1, 0));
        vecs.push_back(mk(0, 1, 32'h0002_0000, 16'd4, 0, 64'd0, 0, 32'd0, 64'd202, 1, 0));
        vecs.push_back(mk(0, 1, 32'h0002_0000, 16'd4, 0, 64'd0, 0, 32'd0, 64'd202, 1, 0));
        vecs.push_back(mk(0, 1, 32'h0002_0000, 16'd4, 0, 64'd0, 0, 32'd0, 64'd202, 1, 0));
        vecs.push_back(mk(0, 1, 32'h0002_0000, 16'd4, 0, 64'd0, 0, 32'd0, 64'd202, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0002_0000, 16'd4, 0, 64'd0, 0, 32'd0, 64'd204, 0, 1));
        vecs.push_back(mk(0, 1, 32'h0002_0000, 16'd4, 0, 64'd0, 0, 32'd0, 64'd206, 0, 1));
        // slew_limit 0 behaves as 1
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd0, 1, 64'd0, 0, 32'd0, 64'd0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd0, 0, 64'd0, 1, 32'd3, 64'd1, 1, 1));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd0, 0, 64'd0, 0, 32'd0, 64'd3, 1, 0));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd0, 0, 64'd0, 0, 32'd0, 64'd5, 1, 0));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd0, 0, 64'd0, 0, 32'd0, 64'd7, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd0, 0, 64'd0, 0, 32'd0, 64'd8, 0, 1));
        // set during slew discards correction; adj_valid with set is ignored
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd1, 1, 64'd0, 0, 32'd0, 64'd0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd1, 0, 64'd0, 1, 32'd1000, 64'd1, 1, 1));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd1, 0, 64'd0, 0, 32'd0, 64'd3, 1, 0));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd1, 0, 64'd0, 0, 32'd0, 64'd5, 1, 0));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd1, 1, 64'h5000, 1, 32'd7, 64'h5000, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd1, 0, 64'd0, 0, 32'd0, 64'h5001, 0, 1));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd1, 0, 64'd0, 0, 32'd0, 64'h5002, 0, 1));
        // reset mid-slew
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd1, 0, 64'd0, 1, 32'd1000, 64'h5003, 1, 1));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd1, 0, 64'd0, 0, 32'd0, 64'h5005, 1, 0));
        vecs.push_back(mk(1, 1, 32'h0001_0000, 16'd1, 0, 64'd0, 0, 32'd0, 64'd0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h0001_0000, 16'd1, 0, 64'd0, 0, 32'd0, 64'd1, 0, 1));

        foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

        // wrap-around at 2^64
        apply(mk(0, 1, 32'h0001_0000, 16'd2, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 32'd0,
                 64'hFFFF_FFFF_FFFF_FFFE, 0, 0), "wrap0");
        apply(mk(0, 1, 32'h0001_0000, 16'd2, 0, 64'd0, 0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1), "wrap1");
        apply(mk(0, 1, 32'h0001_0000, 16'd2, 0, 64'd0, 0, 32'd0, 64'd0, 0, 1), "wrap2");
        apply(mk(0, 1, 32'h0001_0000, 16'd2, 0, 64'd0, 0, 32'd0, 64'd1, 0, 1), "wrap3");
        // enable hold mid-slew: +10 at limit 2, freeze 3 cycles, resume
        apply(mk(0, 1, 32'h0001_0000, 16'd2, 0, 64'd0, 1, 32'd10, 64'd2, 1, 1), "hold_acc");
        apply(mk(0, 1, 32'h0001_0000, 16'd2, 0, 64'd0, 0, 32'd0, 64'd5, 1, 0), "hold_s1");
        for (int k = 0; k < 3; k++)
            apply(mk(0, 0, 32'h0001_0000, 16'd2, 0, 64'd0, 0, 32'd0, 64'd5, 1, 0),
                  $sformatf("hold_off%0d", k));
        apply(mk(0, 1, 32'h0001_0000, 16'd2, 0, 64'd0, 0, 32'd0, 64'd8, 1, 0), "hold_s2");
        apply(mk(0, 1, 32'h0001_0000, 16'd2, 0, 64'd0, 0, 32'd0, 64'd11, 1, 0), "hold_s3");
        apply(mk(0, 1, 32'h0001_0000, 16'd2, 0, 64'd0, 0, 32'd0, 64'd14, 1, 0), "hold_s4");
        apply(mk(0, 1, 32'h0001_0000, 16'd2, 0, 64'd0, 0, 32'd0, 64'd17, 0, 0), "hold_s5");
        apply(mk(0, 1, 32'h0001_0000, 16'd2, 0, 64'd0, 0, 32'd0, 64'd18, 0, 1), "hold_s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
